// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    // Fetch sequencer states: free to issue, one read in flight, in-flight read is stale.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    // Depth of the fetched-instruction queue and width of its occupancy counter.
    localparam int BUF_DEPTH           = 2;
    localparam int CNT_W               = 2;

    // Byte distance between sequential instructions.
    localparam int DEFAULT_INSTR_BYTES = 4;

endpackage : fetch_pkg

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {fetch address, instruction word} between fetch and decode.
// Flush empties the queue in one cycle; the head entry is read straight from storage.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    input  logic               flush,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [CNT_W-1:0]   count
);

    logic [ADDR_W-1:0]  pc_mem_r    [BUF_DEPTH];
    logic [INSTR_W-1:0] instr_mem_r [BUF_DEPTH];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               do_push_s;
    logic               do_pop_s;

    // A flush wins over both push and pop; pop of an empty queue is ignored.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_push_s = push;
            do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
        end
    end

    // Entry storage, written at the write pointer on every accepted push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_mem_r[i]    <= {ADDR_W{1'b0}};
                instr_mem_r[i] <= {INSTR_W{1'b0}};
            end
        end else if (do_push_s) begin
            pc_mem_r[wr_ptr_r]    <= push_pc;
            instr_mem_r[wr_ptr_r] <= push_instr;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_pc    = pc_mem_r[rd_ptr_r];
    assign head_instr = instr_mem_r[rd_ptr_r];
    assign count      = count_r;

endmodule : fetch_buffer

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: issues one imem read at a time from the current PC,
// advances the PC on acceptance, queues responses for decode and applies redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int INSTR_W     = 32,
    parameter int INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_write,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    fetch_state_e       state_r;
    fetch_state_e       state_nxt_s;
    logic [ADDR_W-1:0]  tag_r;
    logic [CNT_W-1:0]   count_s;
    logic               buf_free_s;
    logic               req_valid_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               flush_s;
    logic               pc_write_s;
    logic [ADDR_W-1:0]  next_pc_s;

    // No request is in flight while in S_REQ, so buffer occupancy alone bounds issue.
    assign buf_free_s = (count_s < CNT_W'(BUF_DEPTH));
    assign pop_s      = instr_valid && instr_ready;

    // Next state, request issue, buffer push and PC update; redirect overrides the increment.
    always_comb begin
        state_nxt_s = state_r;
        req_valid_s = 1'b0;
        accept_s    = 1'b0;
        push_s      = 1'b0;
        flush_s     = 1'b0;
        pc_write_s  = 1'b0;
        next_pc_s   = {ADDR_W{1'b0}};
        case (state_r)
            S_REQ: begin
                if (!redirect_valid && buf_free_s) begin
                    req_valid_s = 1'b1;
                    if (imem_req_ready) begin
                        accept_s    = 1'b1;
                        state_nxt_s = S_WAIT;
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    // A response arriving with the redirect is stale and simply dropped.
                    if (imem_rsp_valid) begin
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_DRAIN;
                    end
                end else if (imem_rsp_valid) begin
                    push_s      = 1'b1;
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_DRAIN: begin
                // The stale response retires the outstanding read even if another redirect lands now.
                if (imem_rsp_valid) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: begin
                state_nxt_s = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            pc_write_s = 1'b1;
            next_pc_s  = redirect_pc;
            flush_s    = 1'b1;
        end else if (accept_s) begin
            pc_write_s = 1'b1;
            next_pc_s  = pc + ADDR_W'(INSTR_BYTES);
        end else begin
            pc_write_s = 1'b0;
            next_pc_s  = {ADDR_W{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_REQ;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Address of the in-flight read, attached to its response when it is queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_r <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            tag_r <= pc;
        end
    end

    fetch_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_pc    (tag_r),
        .push_instr (imem_rsp_data),
        .pop        (pop_s),
        .flush      (flush_s),
        .head_pc    (instr_pc),
        .head_instr (instr_data),
        .count      (count_s)
    );

    // Combinational strobes are forced low while reset is held so all outputs read zero.
    assign imem_req_valid = reset && req_valid_s;
    assign imem_req_addr  = imem_req_valid ? pc : {ADDR_W{1'b0}};
    assign pc_write       = reset && pc_write_s;
    assign next_pc        = reset ? next_pc_s : {ADDR_W{1'b0}};
    assign instr_valid    = (count_s != {CNT_W{1'b0}});

endmodule : fetch_unit
